add16_acc_stage: RTL and testbench
==================================

// Module: add16_acc_stage
// PURPOSE
//   Registered accumulator stage that sits around adder16. It stages operands into
//   adder16 (A = accumulator, B = operand or ~operand, Cin) and captures adder16's
//   S/Cout into the accumulator with N/Z/C/V flags. Operations enter through a
//   valid/ready input and results leave through a valid/ready output.
//   Serves as the datapath front-end for the 16-bit CPU ALU path.
// PARAMETERS
//   WIDTH   16   datapath width; only 16 is legal (matches adder16)
//   CNT_W   8    width of the accepted-op counter op_count
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operation presented
//   in_ready   out  1      stage can accept an operation this cycle
//   in_op      in   2      00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   in_data    in   WIDTH  operand (two's complement)
//   add_a      out  WIDTH  to adder16 A = acc
//   add_b      out  WIDTH  to adder16 B = (in_op==SUB) ? ~in_data : in_data
//   add_cin    out  1      to adder16 Cin = (in_op==SUB)
//   add_s      in   WIDTH  from adder16 S (combinational, same cycle)
//   add_cout   in   1      from adder16 Cout
//   out_valid  out  1      result registered and held
//   out_ready  in   1      consumer takes result
//   out_acc    out  WIDTH  accumulator value
//   out_flags  out  4      {N,Z,C,V} of the last accepted op
//   op_count   out  CNT_W  accepted ops since reset/CLEAR, saturating
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge): acc=0, out_valid=0, out_flags=4'b0100 (Z=1),
//     op_count=0. Any pending result is dropped. in_ready=1 in the cycle after reset.
//   - Two states on out_valid: EMPTY(0) and HOLD(1).
//     in_ready = !out_valid || out_ready (combinational; no bubble).
//   - Accept = in_valid && in_ready. On accept at posedge: acc, flags and op_count
//     update, and out_valid<=1. Latency is 1 cycle from accept to out_valid.
//   - HOLD with out_ready=0: out_acc, out_flags and out_valid are stable. No accept.
//   - HOLD with out_ready=1 and no accept: out_valid<=0. Acc is retained.
//   - HOLD with out_ready=1 and accept in the same cycle: the new result is registered
//     and out_valid stays 1. Both handshakes complete.
//   - LOAD: acc<=in_data. C=0, V=0, N=in_data[15], Z=(in_data==0).
//   - ADD/SUB: acc<=add_s. C=add_cout (SUB: C=1 means no borrow).
//     V=(add_a[15]==add_b[15])&&(add_s[15]!=add_a[15]). N/Z are taken from the new acc.
//   - CLEAR: acc<=0, flags=4'b0100, op_count<=0. CLEAR still produces an output beat.
//   - op_count: +1 per accepted non-CLEAR op. It holds at 2^CNT_W-1 and does not wrap.
//   - add_a, add_b and add_cin are driven every cycle regardless of in_valid.
//     Acc changes only on accept.
// CONFIGURATION
//   ADD16_ACC_SAT_EN defined: on an ADD/SUB with V=1, acc clamps to 16'h7FFF if
//     add_a[15]==0, else to 16'h8000. V=1 is still reported, and C is add_cout.
//     N/Z are taken from the clamped value.
//   Not defined: acc wraps modulo 2^16 (acc<=add_s) and V is only reported.
// TESTING
//   1. LOAD 5, ADD 16'hFFFD (-3) -> out_acc=2, flags N0 Z0 C1 V0, op_count=2.
//   2. LOAD 16'h7FFF, ADD 1 -> out_acc=16'h8000, N1 V1; with SAT_EN out_acc=16'h7FFF, V1.
//   3. LOAD 3, SUB 5 -> out_acc=16'hFFFE, N1 Z0 C0 V0. LOAD 5, SUB 5 -> 0, Z1 C1.
//   4. out_ready=0 for 3 cycles after an accept -> in_ready=0, outputs stable.
//      Then out_ready=1 with in_valid=1 -> both handshakes fire, out_valid stays 1.
//   5. rst=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, acc=0,
//      flags=4'b0100, op_count=0, in_ready=1.
//   6. 300 back-to-back ADD 1 with out_ready=1 -> op_count=255, out_acc=300.
//      CLEAR -> op_count=0, out_acc=0.

Source files
------------

// File: rtl/add16_acc_stage_if.sv
// -----------------------------------------------------------------------------
// add16_acc_stage_if
//   Bundle of every non-clock/reset signal around add16_acc_stage. It carries the
//   input operation stream, the output result stream and the link to the
//   external adder16.
//
//   Modports
//     slave  : the accumulator stage itself
//     master : the environment (operation producer, result consumer, adder16)
//
//   Signals (direction as seen by the stage)
//     in_valid  in   1      operation presented
//     in_ready  out  1      stage can accept an operation this cycle
//     in_op     in   2      00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//     in_data   in   WIDTH  operand (two's complement)
//     add_a     out  WIDTH  adder16 A = accumulator
//     add_b     out  WIDTH  adder16 B = operand or ~operand
//     add_cin   out  1      adder16 carry-in (1 for SUB)
//     add_s     in   WIDTH  adder16 sum, combinational
//     add_cout  in   1      adder16 carry-out
//     out_valid out  1      result registered and held
//     out_ready in   1      consumer takes result
//     out_acc   out  WIDTH  accumulator value
//     out_flags out  4      {N,Z,C,V} of the last accepted op
//     op_count  out  CNT_W  accepted non-CLEAR ops, saturating
// -----------------------------------------------------------------------------
interface add16_acc_stage_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_acc;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_op, in_data, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_acc, out_flags, op_count
    );

    modport master (
        output in_valid, in_op, in_data, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_acc, out_flags, op_count
    );
endinterface

// File: rtl/add16_acc_stage.sv
// -----------------------------------------------------------------------------
// add16_acc_stage
//   Registered accumulator stage wrapped around an external adder16. Operands are
//   staged combinationally into the adder (A = acc, B = operand or ~operand,
//   Cin = SUB) and the adder's sum/carry are captured into the accumulator along
//   with {N,Z,C,V} flags. Operations enter on a valid/ready input; results leave
//   on a valid/ready output with one cycle of latency and no bubble.
//
//   Ports
//     clk  in  1  rising-edge clock
//     rst  in  1  synchronous reset, active-high
//     bus  add16_acc_stage_if.slave (operation in, result out, adder16 link)
//
//   Parameters
//     WIDTH  datapath width; only 16 is meaningful (matches adder16)
//     CNT_W  width of op_count
//
//   Configuration macro
//     ADD16_ACC_SAT_EN  defined: signed overflow on ADD/SUB clamps the
//                       accumulator to the most positive/negative value.
//                       Undefined: accumulator wraps, V is only reported.
// -----------------------------------------------------------------------------
module add16_acc_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    add16_acc_stage_if.slave      bus
);
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [3:0] FLAGS_RESET = 4'b0100;  // Z=1 for acc=0

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             is_sub;
    logic             accept;
    logic             ovf;
    logic [WIDTH-1:0] arith_res;

    // Adder staging is unconditional: it follows in_op/in_data every cycle.
    assign is_sub      = (bus.in_op == OP_SUB);
    assign bus.add_a   = acc_q;
    assign bus.add_b   = is_sub ? ~bus.in_data : bus.in_data;
    assign bus.add_cin = is_sub;

    // A held result that is being drained this cycle frees the register, so a
    // new op can be taken in the same cycle.
    assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Signed overflow: operands of equal sign producing a sum of the other sign.
    assign ovf = (bus.add_a[WIDTH-1] == bus.add_b[WIDTH-1]) &&
                 (bus.add_s[WIDTH-1] != bus.add_a[WIDTH-1]);

`ifdef ADD16_ACC_SAT_EN
    // Clamp direction follows A's sign: a positive A can only overflow upwards.
    assign arith_res = !ovf ? bus.add_s :
                       bus.add_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign arith_res = bus.add_s;
`endif

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        count_d = count_q;

        unique case (state_q)
            EMPTY: if (accept) state_d = HOLD;
            HOLD: begin
                if (accept)             state_d = HOLD;
                else if (bus.out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            // Non-CLEAR ops count up and stick at all-ones.
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;

            unique case (bus.in_op)
                OP_LOAD: begin
                    acc_d   = bus.in_data;
                    flags_d = {bus.in_data[WIDTH-1], (bus.in_data == '0), 1'b0, 1'b0};
                end
                OP_ADD, OP_SUB: begin
                    acc_d   = arith_res;
                    flags_d = {arith_res[WIDTH-1], (arith_res == '0), bus.add_cout, ovf};
                end
                OP_CLEAR: begin
                    acc_d   = '0;
                    flags_d = FLAGS_RESET;
                    count_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            flags_q <= FLAGS_RESET;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_flags = flags_q;
    assign bus.op_count  = count_q;

endmodule

// File: tb/tb_add16_acc_stage.sv
// -----------------------------------------------------------------------------
// tb_add16_acc_stage
//   Self-checking bench for add16_acc_stage. The bench plays adder16 with a
//   plain addition, runs a table of directed vectors, hand-written handshake and
//   reset sequences, and a randomized run compared against an integer-arithmetic
//   reference model. Define ADD16_ACC_SAT_EN to check the saturating build.
// -----------------------------------------------------------------------------
module tb_add16_acc_stage;
    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic clk;
    logic rst;

    int checks;
    int failures;

    add16_acc_stage_if #(.WIDTH(16), .CNT_W(8)) bus ();

    add16_acc_stage #(.WIDTH(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // adder16 stand-in
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] m_acc;
    logic [3:0]  m_flags;
    int          m_cnt;
    logic        m_valid;

    task automatic model_reset();
        m_acc = 16'h0; m_flags = 4'b0100; m_cnt = 0; m_valid = 1'b0;
    endtask

    task automatic model_exec(input logic [1:0] op, input logic [15:0] d);
        int sa, sd, sres, ua, ud;
        logic c, v;
        logic [15:0] res;
        sa = $signed(m_acc); sd = $signed(d);
        ua = int'(m_acc);    ud = int'(d);
        if (op == CLEAR) begin
            m_acc = 16'h0; m_flags = 4'b0100; m_cnt = 0;
        end else begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (op == LOAD) begin
                m_acc   = d;
                m_flags = {d[15], d == 16'h0, 2'b00};
            end else begin
                if (op == ADD) begin
                    sres = sa + sd;
                    c    = (ua + ud) > 65535;
                    res  = 16'(ua + ud);
                end else begin
                    sres = sa - sd;
                    c    = ua >= ud;        // no borrow
                    res  = 16'(ua - ud);
                end
                v = (sres > 32767) || (sres < -32768);
`ifdef ADD16_ACC_SAT_EN
                if (v) res = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
                m_acc   = res;
                m_flags = {res[15], res == 16'h0, c, v};
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d, input logic ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, LOAD, 16'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] acc;
        logic [3:0]  flags;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;

        vecs[0]  = '{LOAD,  16'h0005, 16'h0005, 4'b0000, 8'd1};
        vecs[1]  = '{ADD,   16'hFFFD, 16'h0002, 4'b0010, 8'd2};
        vecs[2]  = '{LOAD,  16'h7FFF, 16'h7FFF, 4'b0000, 8'd3};
`ifdef ADD16_ACC_SAT_EN
        vecs[3]  = '{ADD,   16'h0001, 16'h7FFF, 4'b0001, 8'd4};
`else
        vecs[3]  = '{ADD,   16'h0001, 16'h8000, 4'b1001, 8'd4};
`endif
        vecs[4]  = '{LOAD,  16'h0003, 16'h0003, 4'b0000, 8'd5};
        vecs[5]  = '{SUB,   16'h0005, 16'hFFFE, 4'b1000, 8'd6};
        vecs[6]  = '{LOAD,  16'h0005, 16'h0005, 4'b0000, 8'd7};
        vecs[7]  = '{SUB,   16'h0005, 16'h0000, 4'b0110, 8'd8};
        vecs[8]  = '{LOAD,  16'h0000, 16'h0000, 4'b0100, 8'd9};
        vecs[9]  = '{LOAD,  16'h8000, 16'h8000, 4'b1000, 8'd10};
`ifdef ADD16_ACC_SAT_EN
        vecs[10] = '{SUB,   16'h0001, 16'h8000, 4'b1011, 8'd11};
`else
        vecs[10] = '{SUB,   16'h0001, 16'h7FFF, 4'b0011, 8'd11};
`endif
        vecs[11] = '{CLEAR, 16'hABCD, 16'h0000, 4'b0100, 8'd0};

        // ---- reset state ----
        do_reset();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_acc",       {16'd0, bus.out_acc},   32'd0);
        check("rst_flags",     {28'd0, bus.out_flags}, 32'h4);
        check("rst_count",     {24'd0, bus.op_count},  32'd0);

        // ---- directed table ----
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].data, 1'b1);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("vec%0d_acc", i),   {16'd0, bus.out_acc},   {16'd0, vecs[i].acc});
            check($sformatf("vec%0d_flags", i), {28'd0, bus.out_flags}, {28'd0, vecs[i].flags});
            check($sformatf("vec%0d_count", i), {24'd0, bus.op_count},  {24'd0, vecs[i].cnt});
        end
        drive(1'b0, LOAD, 16'h0, 1'b1);
        step();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // ---- backpressure: hold 3 cycles, then dual handshake ----
        do_reset();
        drive(1'b1, LOAD, 16'h1234, 1'b0);
        #1 check("bp_first_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(1'b1, ADD, 16'h0001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_in_ready", k),  {31'd0, bus.in_ready},  32'd0);
            check($sformatf("bp%0d_out_valid", k), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp%0d_acc", k),       {16'd0, bus.out_acc},   32'h1234);
            check($sformatf("bp%0d_flags", k),     {28'd0, bus.out_flags}, 32'h0);
            step();
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("bp_both_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_both_acc",   {16'd0, bus.out_acc},   32'h1235);
        check("bp_both_count", {24'd0, bus.op_count},  32'd2);
        drive(1'b0, LOAD, 16'h0, 1'b1);
        step();
        check("bp_drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_drain_acc",   {16'd0, bus.out_acc},   32'h1235);

        // ---- reset while busy ----
        drive(1'b1, LOAD, 16'h0009, 1'b1);
        step();
        drive(1'b1, ADD, 16'h0007, 1'b0);
        check("rb_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, LOAD, 16'h0, 1'b0);
        #1;
        check("rb_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("rb_acc",      {16'd0, bus.out_acc},   32'd0);
        check("rb_flags",    {28'd0, bus.out_flags}, 32'h4);
        check("rb_count",    {24'd0, bus.op_count},  32'd0);
        check("rb_in_ready", {31'd0, bus.in_ready},  32'd1);

        // ---- 300 back-to-back ADD 1, then CLEAR ----
        do_reset();
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, ADD, 16'h0001, 1'b1);
            step();
        end
        check("b2b_acc",   {16'd0, bus.out_acc},   32'd300);
        check("b2b_count", {24'd0, bus.op_count},  32'd255);
        check("b2b_flags", {28'd0, bus.out_flags}, 32'h0);
        drive(1'b1, CLEAR, 16'h5555, 1'b1);
        step();
        check("clr_valid", {31'd0, bus.out_valid}, 32'd1);
        check("clr_acc",   {16'd0, bus.out_acc},   32'd0);
        check("clr_count", {24'd0, bus.op_count},  32'd0);
        check("clr_flags", {28'd0, bus.out_flags}, 32'h4);

        // ---- randomized run against the reference model ----
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic        v, ordy, acc_ok;
            logic [1:0]  op;
            logic [15:0] d;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 15) == 0) ? CLEAR : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                2:       d = 16'($urandom_range(0, 3));
                default: d = 16'($urandom);
            endcase
            drive(v, op, d, ordy);
            #1;
            check("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || ordy)});
            check("rnd_add_a",    {16'd0, bus.add_a},    {16'd0, m_acc});
            check("rnd_add_b",    {16'd0, bus.add_b},    {16'd0, (op == SUB) ? ~d : d});
            check("rnd_add_cin",  {31'd0, bus.add_cin},  {31'd0, op == SUB});
            acc_ok = v && (!m_valid || ordy);
            step();
            if (acc_ok) begin
                model_exec(op, d);
                m_valid = 1'b1;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            check("rnd_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            check("rnd_acc",       {16'd0, bus.out_acc},   {16'd0, m_acc});
            check("rnd_flags",     {28'd0, bus.out_flags}, {28'd0, m_flags});
            check("rnd_count",     {24'd0, bus.op_count},  32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
